// File: rtl/rv_ex_md_stage_pkg.sv
// rv_ex_md_stage_pkg
// Shared definitions for the execute stage and its iterative multiply/divide
// unit: M-op funct3 codes, ALU op codes, branch funct3 codes, the mul/div FSM
// state type and small funct3 decode helpers.
// No ports (package).

package rv_ex_md_stage_pkg;

    localparam int XLEN_DEFAULT = 32;

    // M-extension funct3 codes
    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    // ALU op codes carried on alu_ctrl
    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    // Branch funct3 codes
    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    function automatic logic md_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic md_is_rem(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

endpackage

// File: rtl/rv_ex_md_stage_muldiv.sv
// rv_ex_md_stage_muldiv
// Iterative RV32M/RV64M multiply/divide unit. Works on operand magnitudes, one
// bit per cycle, and applies the sign in DONE. Divide-by-zero and signed
// overflow resolve without iterating.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          begin an op (honoured only in MD_IDLE)
//   func3          M-op select
//   op_a, op_b     forwarded operands, latched on start
//   busy           iterating
//   done           result valid this cycle
//   result         M-op result (meaningful while done)

module rv_ex_md_stage_muldiv
    import rv_ex_md_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    // state   | meaning
    // MD_IDLE | waiting for start; special divides jump straight to MD_DONE
    // MD_BUSY | one multiply/divide bit per cycle, count 0..XLEN-1
    // MD_DONE | sign-corrected result valid for one cycle

    localparam int CW = $clog2(XLEN);

    md_state_t         state;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] prod;     // mul: {hi,lo} product; div: {rem,quo}
    logic [XLEN-1:0]   opb_mag;
    logic              neg;
    logic [2:0]        op;

    logic            a_neg, b_neg, neg_start, div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b;

    always_comb begin
        a_neg = 1'b0;
        b_neg = 1'b0;
        if (md_is_div(func3)) begin
            a_neg = ~func3[0] & op_a[XLEN-1];
            b_neg = ~func3[0] & op_b[XLEN-1];
        end else begin
            a_neg = (func3[1:0] != 2'b11) & op_a[XLEN-1];
            b_neg = ~func3[1] & op_b[XLEN-1];
        end
        mag_a     = a_neg ? -op_a : op_a;
        mag_b     = b_neg ? -op_b : op_b;
        // remainder takes the dividend's sign, everything else the xor
        neg_start = md_is_rem(func3) ? a_neg : (a_neg ^ b_neg);
        div_zero  = md_is_div(func3) && (op_b == '0);
        div_ovf   = md_is_div(func3) && !func3[0] &&
                    (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    end

    // one shift-add / restoring-subtract step
    logic [XLEN-1:0]   addend, rem_sub;
    logic [XLEN:0]     mul_sum, shifted;
    logic              ge;
    logic [2*XLEN-1:0] mul_next, div_next;

    always_comb begin
        addend   = prod[0] ? opb_mag : '0;
        mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, addend};
        mul_next = {mul_sum, prod[XLEN-1:1]};
        shifted  = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
        ge       = shifted >= {1'b0, opb_mag};
        rem_sub  = shifted[XLEN-1:0] - opb_mag;
        div_next = {(ge ? rem_sub : shifted[XLEN-1:0]), prod[XLEN-2:0], ge};
    end

    logic [2*XLEN-1:0] prod_neg;
    logic [XLEN-1:0]   lo_fix, mul_hi, rem_fix;

    always_comb begin
        prod_neg = -prod;
        lo_fix   = neg ? prod_neg[XLEN-1:0]      : prod[XLEN-1:0];
        mul_hi   = neg ? prod_neg[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
        rem_fix  = neg ? -prod[2*XLEN-1:XLEN]    : prod[2*XLEN-1:XLEN];
        case (op)
            MD_MUL, MD_DIV, MD_DIVU:     result = lo_fix;
            MD_MULH, MD_MULHSU, MD_MULHU: result = mul_hi;
            default:                     result = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= MD_IDLE;
            count   <= '0;
            prod    <= '0;
            opb_mag <= '0;
            neg     <= 1'b0;
            op      <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        op      <= func3;
                        opb_mag <= mag_b;
                        count   <= '0;
                        if (div_zero) begin
                            // quotient all-ones, remainder = raw dividend
                            prod  <= {op_a, {XLEN{1'b1}}};
                            neg   <= 1'b0;
                            state <= MD_DONE;
                        end else if (div_ovf) begin
                            // quotient = dividend, remainder = 0
                            prod  <= {{XLEN{1'b0}}, op_a};
                            neg   <= 1'b0;
                            state <= MD_DONE;
                        end else begin
                            prod  <= {{XLEN{1'b0}}, mag_a};
                            neg   <= neg_start;
                            state <= MD_BUSY;
                        end
                    end
                end
                MD_BUSY: begin
                    prod  <= md_is_div(op) ? div_next : mul_next;
                    count <= count + 1'b1;
                    if (count == CW'(XLEN-1)) state <= MD_DONE;
                end
                MD_DONE: state <= MD_IDLE;
                default: state <= MD_IDLE;
            endcase
        end
    end

    assign busy = (state == MD_BUSY);
    assign done = (state == MD_DONE);

endmodule

// File: rtl/rv_ex_md_stage.sv
// rv_ex_md_stage
// Execute stage: operand forwarding, ALU, branch resolution, EX/MEM register
// and an iterative multiply/divide unit with a stall handshake to the hazard
// unit.
// Optional feature macro: RV_EXMD_FAST_MUL_EN -- when defined, MUL/MULH/
// MULHSU/MULHU use a single-cycle combinational product and never stall;
// divides always iterate.
// Ports:
//   i_exmd_clk, i_exmd_rst       clock, synchronous active-high reset
//   i_exmd_valid                 EX holds a real instruction
//   i_exmd_pc/ext_imm/rf_rd1/rf_rd2, func3, alu_ctrl, decode controls
//   i_exmd_fwd_data              packed forward values, source 0 = MEM
//   i_exmd_rd1_sel/rd2_sel       0 = regfile, k = forward source k-1
//   o_exmd_stall                 hold PC, IF/ID, ID/EX
//   o_exmd_flush_ifid            taken branch or jump
//   o_exmd_if_target_addr        ALU result (redirect target)
//   o_exmd_mem_*                 EX/MEM register

module rv_ex_md_stage
    import rv_ex_md_stage_pkg::*;
#(
    parameter int  XLEN     = XLEN_DEFAULT,
    parameter int  FWD_SRCS = 2,
    localparam int SELW     = $clog2(FWD_SRCS+1)
) (
    input  logic                     i_exmd_clk,
    input  logic                     i_exmd_rst,
    input  logic                     i_exmd_valid,
    input  logic [XLEN-1:0]          i_exmd_pc,
    input  logic [XLEN-1:0]          i_exmd_ext_imm,
    input  logic [XLEN-1:0]          i_exmd_rf_rd1,
    input  logic [XLEN-1:0]          i_exmd_rf_rd2,
    input  logic [2:0]               i_exmd_func3,
    input  logic [3:0]               i_exmd_alu_ctrl,
    input  logic                     i_exmd_alu_a_sel,
    input  logic                     i_exmd_alu_b_sel,
    input  logic                     i_exmd_is_branch,
    input  logic                     i_exmd_is_jump,
    input  logic                     i_exmd_is_load,
    input  logic                     i_exmd_is_md,
    input  logic                     i_exmd_dmem_we,
    input  logic                     i_exmd_rf_we,
    input  logic [2:0]               i_exmd_dmem_bytectrl,
    input  logic [4:0]               i_exmd_rf_wa,
    input  logic [1:0]               i_exmd_rf_wd_pre_sel,
    input  logic [FWD_SRCS*XLEN-1:0] i_exmd_fwd_data,
    input  logic [SELW-1:0]          i_exmd_rd1_sel,
    input  logic [SELW-1:0]          i_exmd_rd2_sel,
    output logic                     o_exmd_stall,
    output logic                     o_exmd_flush_ifid,
    output logic [XLEN-1:0]          o_exmd_if_target_addr,
    output logic                     o_exmd_mem_is_load,
    output logic [XLEN-1:0]          o_exmd_mem_alu_res,
    output logic [XLEN-1:0]          o_exmd_mem_ext_imm,
    output logic [XLEN-1:0]          o_exmd_mem_pc_plus_4,
    output logic                     o_exmd_mem_dmem_we,
    output logic [XLEN-1:0]          o_exmd_mem_dmem_wd,
    output logic [2:0]               o_exmd_mem_dmem_bytectrl,
    output logic                     o_exmd_mem_rf_we,
    output logic [4:0]               o_exmd_mem_rf_wa,
    output logic [1:0]               o_exmd_mem_rf_wd_pre_sel
);

    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] rd1_fwd, rd2_fwd;

    always_comb begin
        rd1_fwd = i_exmd_rf_rd1;
        rd2_fwd = i_exmd_rf_rd2;
        for (int k = 0; k < FWD_SRCS; k++) begin
            if (i_exmd_rd1_sel == SELW'(k+1)) rd1_fwd = i_exmd_fwd_data[k*XLEN +: XLEN];
            if (i_exmd_rd2_sel == SELW'(k+1)) rd2_fwd = i_exmd_fwd_data[k*XLEN +: XLEN];
        end
    end

    logic [XLEN-1:0] alu_a, alu_b, alu_res;
    logic [SHW-1:0]  shamt;

    always_comb begin
        alu_a = i_exmd_alu_a_sel ? i_exmd_pc : rd1_fwd;
        alu_b = i_exmd_alu_b_sel ? rd2_fwd   : i_exmd_ext_imm;
        shamt = alu_b[SHW-1:0];
        case (i_exmd_alu_ctrl)
            ALU_ADD:    alu_res = alu_a + alu_b;
            ALU_SUB:    alu_res = alu_a - alu_b;
            ALU_SLL:    alu_res = alu_a << shamt;
            ALU_SLT:    alu_res = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            ALU_SLTU:   alu_res = {{(XLEN-1){1'b0}}, (alu_a < alu_b)};
            ALU_XOR:    alu_res = alu_a ^ alu_b;
            ALU_SRL:    alu_res = alu_a >> shamt;
            ALU_SRA:    alu_res = $signed(alu_a) >>> shamt;
            ALU_OR:     alu_res = alu_a | alu_b;
            ALU_AND:    alu_res = alu_a & alu_b;
            ALU_PASS_B: alu_res = alu_b;
            default:    alu_res = '0;
        endcase
    end

    logic taken;

    always_comb begin
        case (i_exmd_func3)
            BR_BEQ:  taken = (rd1_fwd == rd2_fwd);
            BR_BNE:  taken = (rd1_fwd != rd2_fwd);
            BR_BLT:  taken = ($signed(rd1_fwd) <  $signed(rd2_fwd));
            BR_BGE:  taken = ($signed(rd1_fwd) >= $signed(rd2_fwd));
            BR_BLTU: taken = (rd1_fwd <  rd2_fwd);
            BR_BGEU: taken = (rd1_fwd >= rd2_fwd);
            default: taken = 1'b0;
        endcase
    end

    logic            fast_mul_op;
    logic [XLEN-1:0] fast_res;

`ifdef RV_EXMD_FAST_MUL_EN
    logic [XLEN:0]            fa, fb;
    logic signed [2*XLEN+1:0] fprod;

    always_comb begin
        fast_mul_op = i_exmd_valid & i_exmd_is_md & ~i_exmd_func3[2];
        // one extra bit lets a single signed multiply cover all four variants
        fa    = {(i_exmd_func3[1:0] != 2'b11) & rd1_fwd[XLEN-1], rd1_fwd};
        fb    = {~i_exmd_func3[1] & rd2_fwd[XLEN-1], rd2_fwd};
        fprod = $signed({{(XLEN+1){fa[XLEN]}}, fa}) * $signed({{(XLEN+1){fb[XLEN]}}, fb});
        fast_res = (i_exmd_func3 == MD_MUL) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
    end
`else
    assign fast_mul_op = 1'b0;
    assign fast_res    = '0;
`endif

    logic            md_iter, md_busy, md_done;
    logic [XLEN-1:0] md_result;

    assign md_iter = i_exmd_valid & i_exmd_is_md & ~fast_mul_op;

    rv_ex_md_stage_muldiv #(.XLEN(XLEN)) u_muldiv (
        .clk    (i_exmd_clk),
        .rst    (i_exmd_rst),
        .start  (md_iter & ~i_exmd_rst),
        .func3  (i_exmd_func3),
        .op_a   (rd1_fwd),
        .op_b   (rd2_fwd),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    // The latch cycle stalls too; DONE releases the pipeline.
    assign o_exmd_stall = ~i_exmd_rst & (md_busy | (md_iter & ~md_busy & ~md_done));

    assign o_exmd_flush_ifid     = i_exmd_valid & ~i_exmd_is_md &
                                   (i_exmd_is_jump | (i_exmd_is_branch & taken));
    assign o_exmd_if_target_addr = alu_res;

    logic            real_cap;
    logic [XLEN-1:0] wb_res;

    assign real_cap = i_exmd_valid & (~i_exmd_is_md | fast_mul_op | md_done);
    assign wb_res   = md_done ? md_result : (fast_mul_op ? fast_res : alu_res);

    always_ff @(posedge i_exmd_clk) begin
        if (i_exmd_rst) begin
            o_exmd_mem_is_load       <= 1'b0;
            o_exmd_mem_alu_res       <= '0;
            o_exmd_mem_ext_imm       <= '0;
            o_exmd_mem_pc_plus_4     <= '0;
            o_exmd_mem_dmem_we       <= 1'b0;
            o_exmd_mem_dmem_wd       <= '0;
            o_exmd_mem_dmem_bytectrl <= '0;
            o_exmd_mem_rf_we         <= 1'b0;
            o_exmd_mem_rf_wa         <= '0;
            o_exmd_mem_rf_wd_pre_sel <= '0;
        end else begin
            o_exmd_mem_is_load       <= real_cap & i_exmd_is_load;
            o_exmd_mem_alu_res       <= wb_res;
            o_exmd_mem_ext_imm       <= i_exmd_ext_imm;
            o_exmd_mem_pc_plus_4     <= i_exmd_pc + XLEN'(4);
            o_exmd_mem_dmem_we       <= real_cap & i_exmd_dmem_we;
            o_exmd_mem_dmem_wd       <= rd2_fwd;
            o_exmd_mem_dmem_bytectrl <= i_exmd_dmem_bytectrl;
            o_exmd_mem_rf_we         <= real_cap & i_exmd_rf_we;
            o_exmd_mem_rf_wa         <= i_exmd_rf_wa;
            o_exmd_mem_rf_wd_pre_sel <= i_exmd_rf_wd_pre_sel;
        end
    end

endmodule

// File: tb/tb_rv_ex_md_stage.sv
module tb_rv_ex_md_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [31:0] pc, imm, rd1, rd2;
    logic [2:0]  func3;
    logic [3:0]  alu_ctrl;
    logic        a_sel, b_sel, is_branch, is_jump, is_load, is_md, dmem_we, rf_we;
    logic [2:0]  bytectrl;
    logic [4:0]  rf_wa;
    logic [1:0]  wd_pre_sel;
    logic [63:0] fwd_data;
    logic [1:0]  rd1_sel, rd2_sel;

    logic        stall, flush;
    logic [31:0] target;
    logic        m_is_load, m_dmem_we, m_rf_we;
    logic [31:0] m_alu_res, m_ext_imm, m_pc4, m_dmem_wd;
    logic [2:0]  m_bytectrl;
    logic [4:0]  m_rf_wa;
    logic [1:0]  m_wd_pre_sel;

    int checks = 0;
    int failures = 0;

`ifdef RV_EXMD_FAST_MUL_EN
    localparam int MUL_STALLS = 0;
`else
    localparam int MUL_STALLS = 33;
`endif

    rv_ex_md_stage #(.XLEN(32), .FWD_SRCS(2)) dut (
        .i_exmd_clk              (clk),
        .i_exmd_rst              (rst),
        .i_exmd_valid            (valid),
        .i_exmd_pc               (pc),
        .i_exmd_ext_imm          (imm),
        .i_exmd_rf_rd1           (rd1),
        .i_exmd_rf_rd2           (rd2),
        .i_exmd_func3            (func3),
        .i_exmd_alu_ctrl         (alu_ctrl),
        .i_exmd_alu_a_sel        (a_sel),
        .i_exmd_alu_b_sel        (b_sel),
        .i_exmd_is_branch        (is_branch),
        .i_exmd_is_jump          (is_jump),
        .i_exmd_is_load          (is_load),
        .i_exmd_is_md            (is_md),
        .i_exmd_dmem_we          (dmem_we),
        .i_exmd_rf_we            (rf_we),
        .i_exmd_dmem_bytectrl    (bytectrl),
        .i_exmd_rf_wa            (rf_wa),
        .i_exmd_rf_wd_pre_sel    (wd_pre_sel),
        .i_exmd_fwd_data         (fwd_data),
        .i_exmd_rd1_sel          (rd1_sel),
        .i_exmd_rd2_sel          (rd2_sel),
        .o_exmd_stall            (stall),
        .o_exmd_flush_ifid       (flush),
        .o_exmd_if_target_addr   (target),
        .o_exmd_mem_is_load      (m_is_load),
        .o_exmd_mem_alu_res      (m_alu_res),
        .o_exmd_mem_ext_imm      (m_ext_imm),
        .o_exmd_mem_pc_plus_4    (m_pc4),
        .o_exmd_mem_dmem_we      (m_dmem_we),
        .o_exmd_mem_dmem_wd      (m_dmem_wd),
        .o_exmd_mem_dmem_bytectrl(m_bytectrl),
        .o_exmd_mem_rf_we        (m_rf_we),
        .o_exmd_mem_rf_wa        (m_rf_wa),
        .o_exmd_mem_rf_wd_pre_sel(m_wd_pre_sel)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        valid = 0; pc = 0; imm = 0; rd1 = 0; rd2 = 0; func3 = 0; alu_ctrl = 0;
        a_sel = 0; b_sel = 0; is_branch = 0; is_jump = 0; is_load = 0; is_md = 0;
        dmem_we = 0; rf_we = 0; bytectrl = 0; rf_wa = 0; wd_pre_sel = 0;
        fwd_data = 0; rd1_sel = 0; rd2_sel = 0;
    endtask

    // Drives one M-op (a via MEM forward, b from regfile), scrambles the
    // forward bus after the latch edge, and reports what it observed.
    task automatic issue_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            output int stalls, output logic [31:0] res, output logic res_we,
                            output logic bubble_bad, output logic flush_seen, output logic timeout);
        @(negedge clk);
        clear_inputs();
        valid = 1; is_md = 1; func3 = f3; rd1_sel = 1; fwd_data = {32'h0, a};
        rd2 = b; b_sel = 1; rf_we = 1; rf_wa = 5'd7; pc = 32'h40;
        stalls = 0; bubble_bad = 0; flush_seen = 0; timeout = 0;
        #1;
        if (flush) flush_seen = 1;
        while (stall === 1'b1 && stalls < 200) begin
            stalls++;
            @(posedge clk);
            #2;
            fwd_data = {$urandom, $urandom};
            @(negedge clk);
            if (m_rf_we !== 1'b0) bubble_bad = 1;
            if (flush) flush_seen = 1;
        end
        if (stalls >= 200) timeout = 1;
        @(negedge clk);
        res = m_alu_res;
        res_we = m_rf_we;
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        valid = 1; is_md = 1; func3 = 3'b000; rf_we = 1; pc = 32'h80;
        @(negedge clk); @(negedge clk);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (m_rf_we !== 1'b0 || m_alu_res !== 32'h0 || m_pc4 !== 32'h0)
            begin failures++; $display("FAIL reset_mem got we=%b res=%h pc4=%h exp 0", m_rf_we, m_alu_res, m_pc4); end
        clear_inputs();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_release_stall got=%b exp=0", stall); end
    endtask

    task automatic test_alu_fwd();
        logic stall_seen;
        stall_seen = 0;
        @(negedge clk);
        clear_inputs();
        valid = 1; alu_ctrl = 4'd0; rd1_sel = 1; fwd_data = {32'h0, 32'h10}; rd1 = 32'h999;
        rd2 = 5; b_sel = 1; rf_we = 1; rf_wa = 5'd3; pc = 32'h100;
        #1;
        if (stall) stall_seen = 1;
        checks++; if (target !== 32'h15) begin failures++; $display("FAIL add_target got=%h exp=15", target); end
        @(negedge clk);
        if (stall) stall_seen = 1;
        checks++; if (m_alu_res !== 32'h15 || m_rf_we !== 1'b1 || m_rf_wa !== 5'd3)
            begin failures++; $display("FAIL add_mem got res=%h we=%b wa=%0d exp 15/1/3", m_alu_res, m_rf_we, m_rf_wa); end
        checks++; if (m_pc4 !== 32'h104) begin failures++; $display("FAIL add_pc4 got=%h exp=104", m_pc4); end
        checks++; if (stall_seen !== 1'b0) begin failures++; $display("FAIL add_stall got=%b exp=0", stall_seen); end
        // SUB, rd2 forwarded from WB
        clear_inputs();
        valid = 1; alu_ctrl = 4'd1; rd1 = 32'h50; rd2_sel = 2; fwd_data = {32'h20, 32'h7};
        rd2 = 32'h1; b_sel = 1; rf_we = 1;
        @(negedge clk);
        checks++; if (m_alu_res !== 32'h30) begin failures++; $display("FAIL sub_wb got=%h exp=30", m_alu_res); end
        // pc + negative immediate
        clear_inputs();
        valid = 1; alu_ctrl = 4'd0; a_sel = 1; pc = 32'h200; imm = 32'hFFFFFFFC; rf_we = 1;
        @(negedge clk);
        checks++; if (m_alu_res !== 32'h1FC) begin failures++; $display("FAIL pc_imm got=%h exp=1fc", m_alu_res); end
        // store data comes from forwarded rd2
        clear_inputs();
        valid = 1; dmem_we = 1; rd2_sel = 1; fwd_data = {32'h0, 32'hCAFE}; rd2 = 32'h1234; bytectrl = 3'b010;
        @(negedge clk);
        checks++; if (m_dmem_wd !== 32'hCAFE || m_dmem_we !== 1'b1 || m_bytectrl !== 3'b010)
            begin failures++; $display("FAIL store got wd=%h we=%b bc=%b exp cafe/1/010", m_dmem_wd, m_dmem_we, m_bytectrl); end
        clear_inputs();
    endtask

    task automatic test_bubble();
        @(negedge clk);
        clear_inputs();
        valid = 0; rf_we = 1; dmem_we = 1; is_load = 1;
        @(negedge clk);
        checks++; if (m_rf_we !== 1'b0 || m_dmem_we !== 1'b0 || m_is_load !== 1'b0)
            begin failures++; $display("FAIL bubble got we=%b dwe=%b ld=%b exp 0", m_rf_we, m_dmem_we, m_is_load); end
        clear_inputs();
    endtask

    task automatic test_branch();
        @(negedge clk);
        clear_inputs();
        valid = 1; is_branch = 1; func3 = 3'b000; rd1 = 5; rd2 = 5;
        #1;
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL beq_taken got=%b exp=1", flush); end
        func3 = 3'b001; #1;
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL bne_not_taken got=%b exp=0", flush); end
        func3 = 3'b100; rd1 = 32'hFFFFFFFF; rd2 = 1; #1;
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL blt_signed got=%b exp=1", flush); end
        func3 = 3'b110; #1;
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL bltu_unsigned got=%b exp=0", flush); end
        is_branch = 0; is_jump = 1; #1;
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL jump got=%b exp=1", flush); end
        clear_inputs();
    endtask

    task automatic test_mul();
        int st; logic [31:0] r; logic we, bb, fl, to;
        issue_md(3'b000, 32'd7, 32'hFFFFFFFD, st, r, we, bb, fl, to);
        checks++; if (st !== MUL_STALLS) begin failures++; $display("FAIL mul_stalls got=%0d exp=%0d", st, MUL_STALLS); end
        checks++; if (r !== 32'hFFFFFFEB || we !== 1'b1) begin failures++; $display("FAIL mul_res got=%h we=%b exp ffffffeb/1", r, we); end
        checks++; if (bb !== 1'b0 || fl !== 1'b0 || to !== 1'b0)
            begin failures++; $display("FAIL mul_bubble_flush got bubble_bad=%b flush=%b timeout=%b exp 0", bb, fl, to); end
        issue_md(3'b001, 32'd7, 32'hFFFFFFFD, st, r, we, bb, fl, to);
        checks++; if (r !== 32'hFFFFFFFF || to !== 1'b0) begin failures++; $display("FAIL mulh got=%h exp=ffffffff", r); end
        issue_md(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, st, r, we, bb, fl, to);
        checks++; if (r !== 32'hFFFFFFFF || to !== 1'b0) begin failures++; $display("FAIL mulhsu got=%h exp=ffffffff", r); end
        issue_md(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, st, r, we, bb, fl, to);
        checks++; if (r !== 32'hFFFFFFFE || st !== MUL_STALLS)
            begin failures++; $display("FAIL mulhu got=%h stalls=%0d exp fffffffe/%0d", r, st, MUL_STALLS); end
    endtask

    task automatic test_div();
        int st; logic [31:0] r; logic we, bb, fl, to;
        issue_md(3'b100, 32'hFFFFFFF9, 32'd2, st, r, we, bb, fl, to);
        checks++; if (r !== 32'hFFFFFFFD || st !== 33 || to !== 1'b0)
            begin failures++; $display("FAIL div_neg got=%h stalls=%0d exp fffffffd/33", r, st); end
        checks++; if (bb !== 1'b0 || we !== 1'b1) begin failures++; $display("FAIL div_bubble got bubble_bad=%b we=%b exp 0/1", bb, we); end
        issue_md(3'b110, 32'hFFFFFFF9, 32'd2, st, r, we, bb, fl, to);
        checks++; if (r !== 32'hFFFFFFFF) begin failures++; $display("FAIL rem_neg got=%h exp=ffffffff", r); end
        issue_md(3'b101, 32'hFFFFFFFF, 32'd16, st, r, we, bb, fl, to);
        checks++; if (r !== 32'h0FFFFFFF) begin failures++; $display("FAIL divu got=%h exp=0fffffff", r); end
        issue_md(3'b111, 32'hFFFFFFFF, 32'd16, st, r, we, bb, fl, to);
        checks++; if (r !== 32'h0000000F) begin failures++; $display("FAIL remu got=%h exp=0000000f", r); end
    endtask

    task automatic test_div_special();
        int st; logic [31:0] r; logic we, bb, fl, to;
        issue_md(3'b100, 32'h80000000, 32'hFFFFFFFF, st, r, we, bb, fl, to);
        checks++; if (r !== 32'h80000000 || st !== 1) begin failures++; $display("FAIL div_ovf got=%h stalls=%0d exp 80000000/1", r, st); end
        issue_md(3'b110, 32'h80000000, 32'hFFFFFFFF, st, r, we, bb, fl, to);
        checks++; if (r !== 32'h0 || st !== 1 || we !== 1'b1) begin failures++; $display("FAIL rem_ovf got=%h stalls=%0d we=%b exp 0/1/1", r, st, we); end
        issue_md(3'b101, 32'd100, 32'd0, st, r, we, bb, fl, to);
        checks++; if (r !== 32'hFFFFFFFF || st !== 1) begin failures++; $display("FAIL divu_zero got=%h stalls=%0d exp ffffffff/1", r, st); end
        issue_md(3'b111, 32'd100, 32'd0, st, r, we, bb, fl, to);
        checks++; if (r !== 32'd100 || st !== 1) begin failures++; $display("FAIL remu_zero got=%h stalls=%0d exp 00000064/1", r, st); end
        issue_md(3'b100, 32'd100, 32'd0, st, r, we, bb, fl, to);
        checks++; if (r !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_zero got=%h exp=ffffffff", r); end
    endtask

    task automatic test_reset_mid();
        logic late_we;
        late_we = 0;
        @(negedge clk);
        clear_inputs();
        valid = 1; is_md = 1; func3 = 3'b100; rd1 = 32'd1000; rd2 = 32'd7; b_sel = 1;
        rf_we = 1; rf_wa = 5'd9; pc = 32'h40;
        repeat (11) @(negedge clk);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", stall); end
        rst = 1;
        clear_inputs();
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mid_rst_stall got=%b exp=0", stall); end
        @(negedge clk);
        checks++; if (m_alu_res !== 32'h0 || m_pc4 !== 32'h0 || m_rf_we !== 1'b0 || m_rf_wa !== 5'd0 || m_dmem_wd !== 32'h0)
            begin failures++; $display("FAIL mid_rst_mem got res=%h pc4=%h we=%b wa=%0d wd=%h exp 0", m_alu_res, m_pc4, m_rf_we, m_rf_wa, m_dmem_wd); end
        rst = 0;
        repeat (40) begin
            @(negedge clk);
            if (m_rf_we !== 1'b0 || stall !== 1'b0) late_we = 1;
        end
        checks++; if (late_we !== 1'b0) begin failures++; $display("FAIL mid_rst_late_wb got=%b exp=0", late_we); end
        valid = 1; alu_ctrl = 4'd0; rd1 = 2; rd2 = 3; b_sel = 1; rf_we = 1;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL post_rst_add_stall got=%b exp=0", stall); end
        @(negedge clk);
        checks++; if (m_alu_res !== 32'd5 || m_rf_we !== 1'b1)
            begin failures++; $display("FAIL post_rst_add got=%h we=%b exp 5/1", m_alu_res, m_rf_we); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_alu_fwd();
        test_bubble();
        test_branch();
        test_mul();
        test_div();
        test_div_special();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rv_ex_md_stage.md
Name: rv_ex_md_stage

Overview:
- Next-generation execute stage: operand forwarding, ALU, branch resolution and EX/MEM pipeline register, plus an iterative RV32M/RV64M multiply/divide unit.
- Adds a pipeline stall handshake while a multi-cycle M-op is in flight.
- Sits between the ID/EX register and the MEM stage, and drives the hazard unit's stall input.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- FWD_SRCS, 2, number of forwarding sources (MEM, WB, optional extra late stage); selector width is clog2(FWD_SRCS+1).

Ports:
- i_exmd_clk  in  1  clock.
- i_exmd_rst  in  1  synchronous reset, active-high.
- i_exmd_valid  in  1  EX holds a real instruction.
- i_exmd_pc, i_exmd_ext_imm, i_exmd_rf_rd1, i_exmd_rf_rd2  in  XLEN  ID/EX operands.
- i_exmd_func3  in  3  funct3.
- i_exmd_alu_ctrl  in  4  ALU op.
- i_exmd_alu_a_sel, i_exmd_alu_b_sel, i_exmd_is_branch, i_exmd_is_jump, i_exmd_is_load, i_exmd_is_md, i_exmd_dmem_we, i_exmd_rf_we  in  1  decode controls.
- i_exmd_dmem_bytectrl  in  3; i_exmd_rf_wa  in  5; i_exmd_rf_wd_pre_sel  in  2.
- i_exmd_fwd_data  in  FWD_SRCS*XLEN  packed forward values; source 0 = MEM.
- i_exmd_rd1_sel, i_exmd_rd2_sel  in  clog2(FWD_SRCS+1)  0 = regfile, k = source k-1.
- o_exmd_stall  out  1  hold PC, IF/ID and ID/EX.
- o_exmd_flush_ifid  out  1  branch taken or jump.
- o_exmd_if_target_addr  out  XLEN  ALU result.
- o_exmd_mem_* (is_load, alu_res, ext_imm, pc_plus_4, dmem_we, dmem_wd, dmem_bytectrl, rf_we, rf_wa, rf_wd_pre_sel)  out  as MEM-stage widths  EX/MEM register.

Behaviour:
- Reset: FSM to IDLE, counter 0; all o_exmd_mem_* cleared to 0; o_exmd_stall 0. Reset mid-operation aborts the M-op with no writeback.
- Non-M op (i_exmd_is_md=0):
  - Single cycle.
  - alu_a = pc when a_sel, else fwd rd1; alu_b = fwd rd2 when b_sel, else imm.
  - Flush computed combinationally from forwarded rd1/rd2 and func3.
  - EX/MEM captured every cycle.
  - i_exmd_valid=0 captures a bubble: rf_we=0, dmem_we=0.
- M op func3 map: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU. On RV64, W-variants are out of scope.
- FSM states: IDLE, BUSY, DONE.
- IDLE & valid & is_md:
  - Latch forwarded operands and func3; o_exmd_stall=1.
  - Special divide cases go straight to DONE.
  - Otherwise go to BUSY with count=0.
- BUSY:
  - Radix-2 shift-add multiply or restoring divide, one bit per cycle on absolute values; sign fixed up in DONE.
  - Exit to DONE when count==XLEN-1.
  - Stall stays 1; EX/MEM captures a bubble each cycle.
- DONE:
  - stall=0; EX/MEM captures the M-op result as alu_res with the instruction's rf_we/rf_wa.
  - Return to IDLE next cycle.
  - Latency: XLEN+1 stall cycles (BUSY path); 1 stall cycle (special case).
- Special divide cases:
  - Divide by zero: DIV/DIVU quotient = all-ones; REM/REMU = dividend.
  - Signed overflow (most-negative / -1): DIV = dividend; REM = 0.
- Forwarding inputs are ignored after the latch cycle, so changing WB values during BUSY must not corrupt the result.
- flush is never asserted for M-ops.
- Simultaneous reset with an M-op start: reset wins.

Optional Feature:
- Macro RV_EXMD_FAST_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU use a combinational 2*XLEN signed product, complete in a single cycle with o_exmd_stall=0, and bypass the FSM; divides are unchanged.
- Undefined: all M-ops take the iterative path.

Decomposition:
- Shared include rv_configs.v holds XLEN and the M-op funct3 localparams (MD_MUL...MD_REMU).
- Existing rv_alu, rv_adder and branch comparator are reused.
- Natural sub-module: rv_muldiv_iter. It owns the FSM, counter and operand/partial registers, with start/busy/done/result handshake. The stage wraps the mux, forwarding and EX/MEM logic around it.

Test Plan:
- ADD, rd1 forwarded from MEM (sel=1, fwd=0x10), rd2=5 -> alu_res 0x15 next cycle, stall never 1.
- MUL 7*-3 (XLEN=32) -> stall high 33 cycles, then alu_res 0xFFFFFFEB, rf_we=1; bubbles (rf_we=0) during stall.
- DIV 0x80000000 / 0xFFFFFFFF -> 1 stall cycle, result 0x80000000; REM -> 0.
- DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100, 1 stall cycle.
- Assert i_exmd_rst at BUSY count 10 -> next cycle stall=0, all outputs 0; a following ADD completes normally.
- RV_EXMD_FAST_MUL_EN defined: MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE, zero stall cycles.
